dfd_dbus_event_capture: RTL

//  Receive end of the debug bus mux tree: samples the final DEBUG_BUS_WIDTH debug bus and detects

---
 rtl/dfd_dbus_event_capture.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/dfd_dbus_event_capture.sv
// Debug bus event capture: detects payload changes on the final debug bus, stamps each change
// with {coarse tick counter, fine stamp from the bus} and queues it for a valid/ready reader.
module dfd_dbus_event_capture #(
    parameter int DEBUG_BUS_WIDTH = 64,
    parameter int FINE_W          = 8,
    parameter int COARSE_W        = 24,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [DEBUG_BUS_WIDTH-1:0]          debug_bus,
    input  logic                                debug_bus_vld,
    input  logic                                Time_Tick,
    input  logic                                capture_en,
    input  logic                                capture_clr,
    output logic                                evt_valid,
    input  logic                                evt_ready,
    output logic [DEBUG_BUS_WIDTH-FINE_W-1:0]   evt_payload,
    output logic [COARSE_W+FINE_W-1:0]          evt_tstamp,
    output logic [$clog2(FIFO_DEPTH):0]         evt_level,
    output logic                                evt_overflow,
    output logic [15:0]                         drop_count
);

    localparam int PAY_W = DEBUG_BUS_WIDTH - FINE_W;
    localparam int TS_W  = COARSE_W + FINE_W;
    localparam int EVT_W = PAY_W + TS_W;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;
    logic [COARSE_W-1:0] coarse_r;
    logic [PAY_W-1:0]   prev_payload_r;
    logic [EVT_W-1:0]   mem_r [FIFO_DEPTH];
    logic [LVL_W-1:0]   wr_ptr_r;
    logic [LVL_W-1:0]   rd_ptr_r;
    logic [LVL_W-1:0]   wr_ptr_nx_s;
    logic [LVL_W-1:0]   rd_ptr_nx_s;
    logic [LVL_W-1:0]   level_s;
    logic               valid_r;
    logic [LVL_W-1:0]   level_r;
    logic               overflow_r;
    logic [15:0]        drop_count_r;

    logic [PAY_W-1:0]   payload_s;
    logic [EVT_W-1:0]   event_s;
    logic               push_s;
    logic               load_prev_s;
    logic               empty_s;
    logic               full_s;
    logic               pop_s;
    logic               wr_en_s;
    logic               drop_s;

    assign payload_s = debug_bus[DEBUG_BUS_WIDTH-1:FINE_W];
    // The coarse value is the one held this cycle, before any same-cycle tick lands.
    assign event_s   = {payload_s, coarse_r, debug_bus[FINE_W-1:0]};

    // Capture FSM next state and push decision; clear overrides everything.
    always_comb begin
        state_nx_s  = state_r;
        push_s      = 1'b0;
        load_prev_s = 1'b0;
        if (capture_clr) begin
            state_nx_s = capture_en ? ST_PRIME : ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (capture_en) begin
                        state_nx_s = ST_PRIME;
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_PRIME: begin
                    if (!capture_en) begin
                        state_nx_s = ST_IDLE;
                    end else if (debug_bus_vld) begin
                        push_s      = 1'b1;
                        load_prev_s = 1'b1;
                        state_nx_s  = ST_RUN;
                    end else begin
                        state_nx_s = ST_PRIME;
                    end
                end
                ST_RUN: begin
                    load_prev_s = debug_bus_vld;
                    push_s      = debug_bus_vld & capture_en & (payload_s != prev_payload_r);
                    if (!capture_en) begin
                        state_nx_s = ST_IDLE;
                    end else begin
                        state_nx_s = ST_RUN;
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                end
            endcase
        end
    end

    // FIFO pointer arithmetic; a full FIFO still accepts a push when the head pops that cycle.
    always_comb begin
        level_s = wr_ptr_r - rd_ptr_r;
        empty_s = (level_s == {LVL_W{1'b0}});
        full_s  = (level_s == LVL_W'(FIFO_DEPTH));
        pop_s   = ~empty_s & evt_ready;
        wr_en_s = push_s & (~full_s | pop_s);
        drop_s  = push_s & full_s & ~pop_s;
        if (capture_clr) begin
            wr_ptr_nx_s = {LVL_W{1'b0}};
            rd_ptr_nx_s = {LVL_W{1'b0}};
        end else begin
            wr_ptr_nx_s = wr_ptr_r + {{AW{1'b0}}, wr_en_s};
            rd_ptr_nx_s = rd_ptr_r + {{AW{1'b0}}, pop_s};
        end
    end

    // Control state, counters, pointers and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            coarse_r       <= {COARSE_W{1'b0}};
            prev_payload_r <= {PAY_W{1'b0}};
            wr_ptr_r       <= {LVL_W{1'b0}};
            rd_ptr_r       <= {LVL_W{1'b0}};
            valid_r        <= 1'b0;
            level_r        <= {LVL_W{1'b0}};
            overflow_r     <= 1'b0;
            drop_count_r   <= 16'd0;
        end else begin
            state_r  <= state_nx_s;
            wr_ptr_r <= wr_ptr_nx_s;
            rd_ptr_r <= rd_ptr_nx_s;
            valid_r  <= (wr_ptr_nx_s != rd_ptr_nx_s);
            level_r  <= wr_ptr_nx_s - rd_ptr_nx_s;
            if (load_prev_s) begin
                prev_payload_r <= payload_s;
            end else begin
                prev_payload_r <= prev_payload_r;
            end
            if (capture_clr) begin
                coarse_r     <= {COARSE_W{1'b0}};
                overflow_r   <= 1'b0;
                drop_count_r <= 16'd0;
            end else begin
                if (Time_Tick) begin
                    coarse_r <= coarse_r + {{(COARSE_W-1){1'b0}}, 1'b1};
                end else begin
                    coarse_r <= coarse_r;
                end
                if (drop_s) begin
                    overflow_r <= 1'b1;
                    if (drop_count_r != 16'hFFFF) begin
                        drop_count_r <= drop_count_r + 16'd1;
                    end else begin
                        drop_count_r <= drop_count_r;
                    end
                end else begin
                    overflow_r   <= overflow_r;
                    drop_count_r <= drop_count_r;
                end
            end
        end
    end

    // Event storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {EVT_W{1'b0}};
            end
        end else if (wr_en_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= event_s;
        end else begin
            mem_r[wr_ptr_r[AW-1:0]] <= mem_r[wr_ptr_r[AW-1:0]];
        end
    end

    assign evt_valid    = valid_r;
    assign evt_level    = level_r;
    assign evt_overflow = overflow_r;
    assign drop_count   = drop_count_r;
    assign evt_payload  = mem_r[rd_ptr_r[AW-1:0]][EVT_W-1:TS_W];
    assign evt_tstamp   = mem_r[rd_ptr_r[AW-1:0]][TS_W-1:0];

endmodule
